// File: rtl/d_trigger_reg.sv
// rtl/d_trigger_reg.sv - Edge-triggered D register with synchronous active-high reset; optional X-accurate model under D_TRIGGER_XPROP_EN
module d_trigger_reg #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    output logic [WIDTH-1:0] Q,
    input  logic             RST,
    input  logic             CP,
    input  logic [WIDTH-1:0] D
);

`ifdef D_TRIGGER_XPROP_EN
    // Level of CP just before the current transition, used to spot 0->X and X->1 edges.
    logic cp_last;

    always @(CP) begin
        cp_last <= CP;
    end

    always @(posedge CP) begin
        if (cp_last !== 1'b0 || CP !== 1'b1) begin
            for (int i = 0; i < WIDTH; i++) begin
                Q[i] <= (D[i] === Q[i]) ? Q[i] : 1'bx;
            end
        end else if (RST === 1'b1) begin
            Q <= RESET_VALUE;
        end else if (RST === 1'b0) begin
            for (int i = 0; i < WIDTH; i++) begin
                Q[i] <= (D[i] === 1'b0 || D[i] === 1'b1) ? D[i] : 1'bx;
            end
        end else begin
            // Unknown reset: only bits already settled at the reset value and fed that value survive.
            for (int i = 0; i < WIDTH; i++) begin
                Q[i] <= (D[i] === RESET_VALUE[i] && Q[i] === RESET_VALUE[i]) ? RESET_VALUE[i] : 1'bx;
            end
        end
    end
`else
    always_ff @(posedge CP) begin
        if (RST) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= D;
        end
    end
`endif

endmodule

// File: tb/tb_d_trigger_reg.sv
// tb/tb_d_trigger_reg.sv - Directed self-checking bench for d_trigger_reg (1-bit and 8-bit instances)
`timescale 1ns/1ps
module tb_d_trigger_reg;

    logic       cp;
    logic       rst;
    logic       d;
    logic       q;
    logic       rst_w;
    logic [7:0] d_w;
    logic [7:0] q_w;

    int checks = 0;
    int errors = 0;

    d_trigger_reg #(.WIDTH(1), .RESET_VALUE(1'b0)) dut_bit (
        .Q  (q),
        .RST(rst),
        .CP (cp),
        .D  (d)
    );

    d_trigger_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut_byte (
        .Q  (q_w),
        .RST(rst_w),
        .CP (cp),
        .D  (d_w)
    );

    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    task automatic test_reset();
        d = 1'b0;
        rst = 1'b0;
        #3 rst = 1'b1;
        @(posedge cp);
        #1 rst = 1'b0;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL reset_edge q=%b expected=%b", q, 1'b0);
        end
    endtask

    task automatic test_capture();
        #6 d = 1'b1;
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL no_comb_path q=%b expected=%b", q, 1'b0);
        end
        @(posedge cp);
        #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL capture_one q=%b expected=%b", q, 1'b1);
        end
        #6 d = 1'b0;
        @(posedge cp);
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL capture_zero q=%b expected=%b", q, 1'b0);
        end
    endtask

    task automatic test_rst_pulse_q0();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        @(posedge cp);
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL rst_pulse_q0 q=%b expected=%b", q, 1'b0);
        end
    endtask

    task automatic test_d_glitch();
        d = 1'b1;
        #3 d = 1'b0;
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL glitch_mid q=%b expected=%b", q, 1'b0);
        end
        @(posedge cp);
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL glitch_edge q=%b expected=%b", q, 1'b0);
        end
    endtask

    task automatic test_falling_edge();
        d = 1'b1;
        @(negedge cp);
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL falling_edge q=%b expected=%b", q, 1'b0);
        end
    endtask

    task automatic test_rst_priority();
        rst = 1'b1;
        d = 1'b1;
        @(posedge cp);
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority q=%b expected=%b", q, 1'b0);
        end
        rst = 1'b0;
        @(posedge cp);
        #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL rst_release q=%b expected=%b", q, 1'b1);
        end
    endtask

    task automatic test_rst_pulse_q1();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        @(posedge cp);
        #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL rst_pulse_q1 q=%b expected=%b", q, 1'b1);
        end
    endtask

    task automatic test_rst_sync_only();
        rst = 1'b1;
        #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL rst_not_async q=%b expected=%b", q, 1'b1);
        end
        @(posedge cp);
        #1;
        rst = 1'b0;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL rst_next_edge q=%b expected=%b", q, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] pattern;
        pattern = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            d = pattern[i];
            @(posedge cp);
            #1;
            checks++;
            if (q !== pattern[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d] q=%b expected=%b", i, q, pattern[i]);
            end
        end
    endtask

    task automatic test_wide();
        d_w = 8'h3C;
        rst_w = 1'b1;
        @(posedge cp);
        #1;
        checks++;
        if (q_w !== 8'hA5) begin
            errors++;
            $display("FAIL wide_reset q=%h expected=%h", q_w, 8'hA5);
        end
        rst_w = 1'b0;
        @(posedge cp);
        #1;
        checks++;
        if (q_w !== 8'h3C) begin
            errors++;
            $display("FAIL wide_capture q=%h expected=%h", q_w, 8'h3C);
        end
        d_w = 8'h5A;
        @(posedge cp);
        #1;
        checks++;
        if (q_w !== 8'h5A) begin
            errors++;
            $display("FAIL wide_capture2 q=%h expected=%h", q_w, 8'h5A);
        end
        d_w = 8'hFF;
        rst_w = 1'b1;
        @(posedge cp);
        #1;
        rst_w = 1'b0;
        checks++;
        if (q_w !== 8'hA5) begin
            errors++;
            $display("FAIL wide_reset2 q=%h expected=%h", q_w, 8'hA5);
        end
        d_w = 8'h00;
        #2;
        checks++;
        if (q_w !== 8'hA5) begin
            errors++;
            $display("FAIL wide_hold q=%h expected=%h", q_w, 8'hA5);
        end
`ifdef D_TRIGGER_XPROP_EN
        d_w = 8'hxx;
        @(posedge cp);
        #1;
        checks++;
        if (q_w !== 8'hxx) begin
            errors++;
            $display("FAIL wide_xprop q=%h expected=%h", q_w, 8'hxx);
        end
`endif
    endtask

    initial begin
        rst_w = 1'b0;
        d_w = 8'h00;
        test_reset();
        test_capture();
        test_rst_pulse_q0();
        test_d_glitch();
        test_falling_edge();
        test_rst_priority();
        test_rst_pulse_q1();
        test_rst_sync_only();
        test_back_to_back();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
